conv2d_stream_engine: RTL and testbench

//  Parametrised, sequential 2-D convolution engine for the accelerator datapath.

---
 rtl/conv_pkg.sv | 47 ++++
 rtl/conv_mac_acc.sv | 38 +++
 rtl/conv2d_stream_engine.sv | 159 +++++++++++++++
 tb/tb_conv2d_stream_engine.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// conv_pkg : shared types and helpers for the 2-D convolution stream engine
// Rev 1.0
// ============================================================================
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_K = 3'd1,
    MAC    = 3'd2,
    OUT    = 3'd3,
    DONE   = 3'd4
  } conv_state_e;

  // Wide enough for any accumulator the engine is built with.
  localparam int SAT_W = 64;

  function automatic int out_dim(input int in_sz, input int k, input int stride);
    return (in_sz - k) / stride + 1;
  endfunction

  // Floor shift by frac_w, then clamp into a signed data_w-bit range.
  function automatic logic signed [SAT_W-1:0] sat_shift(
    input logic signed [SAT_W-1:0] acc,
    input int                      frac_w,
    input int                      data_w
  );
    logic signed [SAT_W-1:0] sh;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    logic signed [SAT_W-1:0] res;
    sh = acc >>> frac_w;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (sh > hi) begin
      res = hi;
    end else if (sh < lo) begin
      res = lo;
    end else begin
      res = sh;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_mac_acc.sv
`default_nettype none
// ============================================================================
// conv_mac_acc : signed multiply-accumulate with shift/saturate output
// Rev 1.0
// ============================================================================
module conv_mac_acc
  import conv_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int FRAC_W = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [DATA_W-1:0] coef,
  output logic signed [DATA_W-1:0] result
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc;

  assign prod = sample * coef;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

  assign result = DATA_W'(sat_shift(SAT_W'(acc), FRAC_W, DATA_W));

endmodule
`default_nettype wire

// File: rtl/conv2d_stream_engine.sv
`default_nettype none
// ============================================================================
// conv2d_stream_engine : sequential 2-D convolution, one MAC, raster output
// Rev 1.0
// ============================================================================
module conv2d_stream_engine
  import conv_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int IN_H   = 227,
  parameter int IN_W   = 227,
  parameter int K      = 11,
  parameter int STRIDE = 4,
  parameter int FRAC_W = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(K*K)-1:0]        k_addr,
  output logic                          k_rd,
  input  logic signed [DATA_W-1:0]      k_data,
  output logic [$clog2(IN_H*IN_W)-1:0]  in_addr,
  output logic                          in_rd,
  input  logic signed [DATA_W-1:0]      in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [DATA_W-1:0]      out_data
);

  localparam int KK    = K * K;
  localparam int KA_W  = $clog2(KK);
  localparam int IA_W  = $clog2(IN_H * IN_W);
  localparam int CNT_W = $clog2(KK + 1);
  localparam int MN_W  = (K > 1) ? $clog2(K) : 1;
  localparam int OUT_H = out_dim(IN_H, K, STRIDE);
  localparam int OUT_W = out_dim(IN_W, K, STRIDE);
  localparam int I_W   = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int J_W   = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  conv_state_e state, next_state;

  logic [CNT_W-1:0]        cnt;
  logic [MN_W-1:0]         m, n;
  logic [I_W-1:0]          i;
  logic [J_W-1:0]          j;
  logic [KA_W-1:0]         kidx_d;
  logic                    k_rd_d, in_rd_d;
  logic signed [DATA_W-1:0] kreg [KK];
  logic                    phase_end, last_pix;
  int                      row, col, lin;

  assign phase_end = (cnt == CNT_W'(KK));
  assign last_pix  = (i == I_W'(OUT_H - 1)) && (j == J_W'(OUT_W - 1));

  always_comb begin
    next_state = state;
    busy       = (state != IDLE);
    done       = 1'b0;
    k_rd       = 1'b0;
    in_rd      = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE:   if (start) next_state = LOAD_K;
      LOAD_K: begin
        k_rd = !phase_end;
        if (phase_end) next_state = MAC;
      end
      MAC: begin
        in_rd = !phase_end;
        if (phase_end) next_state = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) next_state = last_pix ? DONE : MAC;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Addresses idle at zero whenever the matching strobe is low.
  always_comb begin
    row     = int'(i) * STRIDE + int'(m);
    col     = int'(j) * STRIDE + int'(n);
    lin     = row * IN_W + col;
    k_addr  = k_rd  ? KA_W'(cnt) : '0;
    in_addr = in_rd ? IA_W'(lin) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      m       <= '0;
      n       <= '0;
      i       <= '0;
      j       <= '0;
      kidx_d  <= '0;
      k_rd_d  <= 1'b0;
      in_rd_d <= 1'b0;
      for (int idx = 0; idx < KK; idx++) kreg[idx] <= '0;
    end else begin
      state   <= next_state;
      k_rd_d  <= k_rd;
      in_rd_d <= in_rd;
      kidx_d  <= KA_W'(cnt);
      if (k_rd_d) kreg[kidx_d] <= k_data;

      // Phase counter and window offsets restart on every state change.
      if (state != next_state) begin
        cnt <= '0;
        m   <= '0;
        n   <= '0;
      end else if (state == LOAD_K || state == MAC) begin
        cnt <= cnt + 1'b1;
        if (n == MN_W'(K - 1)) begin
          n <= '0;
          m <= m + 1'b1;
        end else begin
          n <= n + 1'b1;
        end
      end

      if (state == IDLE) begin
        i <= '0;
        j <= '0;
      end else if (state == OUT && out_ready) begin
        if (j == J_W'(OUT_W - 1)) begin
          j <= '0;
          i <= (i == I_W'(OUT_H - 1)) ? '0 : i + 1'b1;
        end else begin
          j <= j + 1'b1;
        end
      end
    end
  end

  conv_mac_acc #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .FRAC_W (FRAC_W)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clear  ((state != MAC) && (next_state == MAC)),
    .en     (in_rd_d),
    .sample (in_data),
    .coef   (kreg[kidx_d]),
    .result (out_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_conv2d_stream_engine.sv
`default_nettype none
// ============================================================================
// tb_conv2d_stream_engine : three engine configurations against a window-sum model
// Rev 1.0
// ============================================================================
module tb_conv2d_stream_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] start     = '0;
  logic [2:0] out_ready = '1;
  wire  [2:0] busy, done, k_rd, in_rd, out_valid;
  wire  [3:0] ka0, ka1, ka2;
  wire  [4:0] ia0, ia2;
  wire  [5:0] ia1;
  wire  signed [15:0] od0, od1, od2;
  logic signed [15:0] k_data = '0;
  logic signed [15:0] in_data = '0;

  // 0: 5x5 stride 1, 1: 7x7 stride 2, 2: 5x5 stride 1 with FRAC_W=4
  conv2d_stream_engine #(.DATA_W(16), .ACC_W(40), .IN_H(5), .IN_W(5), .K(3), .STRIDE(1), .FRAC_W(0)) dut_a (
    .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .k_addr(ka0), .k_rd(k_rd[0]), .k_data(k_data), .in_addr(ia0), .in_rd(in_rd[0]),
    .in_data(in_data), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(od0));
  conv2d_stream_engine #(.DATA_W(16), .ACC_W(40), .IN_H(7), .IN_W(7), .K(3), .STRIDE(2), .FRAC_W(0)) dut_b (
    .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .k_addr(ka1), .k_rd(k_rd[1]), .k_data(k_data), .in_addr(ia1), .in_rd(in_rd[1]),
    .in_data(in_data), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(od1));
  conv2d_stream_engine #(.DATA_W(16), .ACC_W(40), .IN_H(5), .IN_W(5), .K(3), .STRIDE(1), .FRAC_W(4)) dut_c (
    .clk(clk), .rst(rst), .start(start[2]), .busy(busy[2]), .done(done[2]),
    .k_addr(ka2), .k_rd(k_rd[2]), .k_data(k_data), .in_addr(ia2), .in_rd(in_rd[2]),
    .in_data(in_data), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(od2));

  logic signed [15:0] img [64];
  logic signed [15:0] ker [16];
  longint exp_q [$];
  longint got [64];
  int sel = 0, rmode = 0, nbeats = 0, ndone = 0, cyc_busy = 0, stall_left = 0;
  bit poke_en = 1'b0, stalling = 1'b0;
  longint stall_val = 0;
  int vectors = 0, miscompares = 0;

  logic cur_valid, cur_krd, cur_inrd, cur_busy, cur_done;
  logic signed [15:0] cur_od;
  logic [3:0] cur_ka;
  logic [5:0] cur_ia;
  always_comb begin
    cur_valid = out_valid[sel];
    cur_krd   = k_rd[sel];
    cur_inrd  = in_rd[sel];
    cur_busy  = busy[sel];
    cur_done  = done[sel];
    case (sel)
      0:       begin cur_od = od0; cur_ka = ka0; cur_ia = {1'b0, ia0}; end
      1:       begin cur_od = od1; cur_ka = ka1; cur_ia = ia1;         end
      default: begin cur_od = od2; cur_ka = ka2; cur_ia = {1'b0, ia2}; end
    endcase
  end

  task automatic chk(input string nm, input longint got_v, input longint exp_v);
    vectors++;
    if (got_v !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got_v, exp_v, $time);
    end
  endtask

  // Single-cycle-latency memories shared by whichever engine is active.
  always @(posedge clk) begin
    if (cur_krd)  k_data  <= ker[cur_ka];
    if (cur_inrd) in_data <= img[cur_ia];
  end

  always @(posedge clk) begin
    #1;
    case (rmode)
      1: out_ready = {3{($urandom_range(0, 2) != 0)}};
      2: if (cur_valid && nbeats == 2 && stall_left > 0) begin
           out_ready = '0;
           stall_left--;
         end else begin
           out_ready = '1;
         end
      default: out_ready = '1;
    endcase
    if (poke_en) start[sel] = (cur_krd || cur_valid || cur_done);
  end

  // Compare process: every accepted beat against the model queue, plus stall behaviour.
  always @(negedge clk) begin
    if (!rst) begin
      if (cur_busy) cyc_busy++;
      if (cur_done) ndone++;
      if (cur_valid) chk("no_reads_in_out", {cur_krd, cur_inrd}, 0);
      if (cur_valid && out_ready[sel]) begin
        if (exp_q.size() == 0) chk("extra_beat", 1, 0);
        else chk("beat", cur_od, exp_q.pop_front());
        if (nbeats < 64) got[nbeats] = cur_od;
        nbeats++;
        stalling = 1'b0;
      end else if (cur_valid) begin
        if (stalling) chk("stall_hold", cur_od, stall_val);
        stall_val = cur_od;
        stalling  = 1'b1;
      end
    end
  end

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference: plain window sums over the bench's own memory images.
  task automatic build_exp(input int d);
    int w, s, f, od;
    longint sum;
    w  = (d == 1) ? 7 : 5;
    s  = (d == 1) ? 2 : 1;
    f  = (d == 2) ? 4 : 0;
    od = (w - 3) / s + 1;
    exp_q.delete();
    for (int oi = 0; oi < od; oi++)
      for (int oj = 0; oj < od; oj++) begin
        sum = 0;
        for (int mm = 0; mm < 3; mm++)
          for (int nn = 0; nn < 3; nn++)
            sum += longint'(img[(oi * s + mm) * w + oj * s + nn]) * longint'(ker[mm * 3 + nn]);
        exp_q.push_back(sat16(sum >>> f));
      end
  endtask

  task automatic fill(input int iv, input int kv);
    for (int x = 0; x < 64; x++) img[x] = 16'(iv);
    for (int x = 0; x < 16; x++) ker[x] = 16'(kv);
  endtask

  task automatic begin_frame(input int d, input int mode);
    sel = d; rmode = mode; build_exp(d);
    nbeats = 0; ndone = 0; cyc_busy = 0; stall_left = 5; stalling = 1'b0;
    @(posedge clk); #2;
    start[d] = 1'b1;
    @(posedge clk); #2;
    start[d] = 1'b0;
  endtask

  task automatic run_frame(input int d, input int mode, input bit poke, input int exp_cycles);
    begin_frame(d, mode);
    poke_en = poke;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      if (ndone > 0) break;
    end
    repeat (20) @(posedge clk);
    #2;
    poke_en = 1'b0;
    start   = '0;
    chk("done_seen", ndone, 1);
    chk("beat_count", nbeats, 9);
    chk("model_left", exp_q.size(), 0);
    chk("idle_after", busy[d], 0);
    if (exp_cycles > 0) chk("frame_cycles", cyc_busy, exp_cycles);
    rmode = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint sc2 [9];
    sc2 = '{8, 10, 12, 22, 24, 26, 36, 38, 40};
    fill(0, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd", {k_rd, in_rd}, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", od0, 0);
    rst = 1'b0;

    // Scenario 1: all ones, 3x3 -> nine 9s in 110 cycles
    fill(1, 1);
    run_frame(0, 0, 1'b0, 110);
    chk("s1_first", got[0], 9);
    chk("s1_last", got[8], 9);

    // Scenario 2: ramp image, centre-tap kernel, stride 2
    fill(0, 0);
    for (int r = 0; r < 7; r++) for (int c = 0; c < 7; c++) img[r * 7 + c] = 16'(r * 7 + c);
    ker[4] = 16'sd1;
    run_frame(1, 0, 1'b0, 110);
    for (int x = 0; x < 9; x++) chk("s2_literal", got[x], sc2[x]);

    // Scenario 3: saturation both ways, then FRAC_W=4 floor shift
    fill(32767, 32767);
    run_frame(0, 0, 1'b0, 110);
    chk("sat_pos", got[4], 32767);
    fill(32767, -32768);
    run_frame(0, 0, 1'b0, 110);
    chk("sat_neg", got[4], -32768);
    fill(0, 1);
    img[0] = 16'sd35;
    img[24] = -16'sd1;
    run_frame(2, 0, 1'b0, 110);
    chk("frac_35", got[0], 2);
    chk("frac_zero", got[4], 0);
    chk("frac_m1", got[8], -1);

    // Scenario 4: five-cycle stall on beat 2
    fill(1, 1);
    run_frame(0, 2, 1'b0, 115);
    chk("bp_value", got[2], 9);

    // Scenario 5: reset in the middle of beat 4's accumulation
    begin_frame(0, 0);
    for (int c = 0; c < 2000 && nbeats < 4; c++) @(posedge clk);
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_in_mac", in_rd[0], 1);
    rst = 1'b1;
    @(posedge clk);
    #2;
    chk("mid_rst_ctrl", {busy[0], done[0], k_rd[0], in_rd[0], out_valid[0]}, 0);
    chk("mid_rst_addr", {ka0, ia0}, 0);
    chk("mid_rst_data", od0, 0);
    rst = 1'b0;
    run_frame(0, 0, 1'b0, 110);
    chk("post_rst_value", got[0], 9);

    // Scenario 6: stray start pulses during LOAD_K, OUT and DONE
    run_frame(0, 0, 1'b1, 110);

    // Randomised frames with random backpressure
    for (int t = 0; t < 6; t++) begin
      for (int x = 0; x < 64; x++) img[x] = 16'($urandom);
      for (int x = 0; x < 16; x++) ker[x] = (t % 3 == 0) ? 16'($urandom_range(0, 15)) - 16'sd8 : 16'($urandom);
      run_frame(1 + (t % 2), 1, 1'b0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
